// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit-adjust constants mirror the add-3 cell of the binary-to-BCD path.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_SUB    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Input/output valid-ready handshake bundle for bcd2bin.
// master = producer/consumer side, slave = converter side.
interface bcd2bin_if #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bin;
  logic                  out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd2bin_digit_adj.sv
// Combinational reverse-dabble correction for one BCD nibble: >= 8 becomes -3.
// Counterpart of the add-3 cell used by the binary-to-BCD converter.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_nib,
  output logic [BCD_DIGIT_W-1:0] o_nib
);

  assign o_nib = (i_nib >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ?
                 i_nib - BCD_DIGIT_W'(BCD_ADJ_SUB) : i_nib;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one bit per clock.
// Result appears WIDTH cycles after accept and is held until out_ready.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd2bin_if.slave    bus
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  bcd_state_t        r_state;
  bcd_state_t        w_state_nxt;
  logic [SW-1:0]     r_scr;
  logic [SW-1:0]     w_shift;
  logic [SW-1:0]     w_iter;
  logic [CW-1:0]     r_cnt;
  logic              r_err;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_bin;
  logic              r_out_err;
  logic              w_in_err;
  logic              w_last;

  assign w_shift = r_scr >> 1;
  assign w_iter[WIDTH-1:0] = w_shift[WIDTH-1:0];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (w_shift[WIDTH + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
      .o_nib (w_iter [WIDTH + BCD_DIGIT_W*gi +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_in_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      w_in_err = w_in_err | digit_bad(bus.in_bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W]);
    end
  end

  // Leave SHIFT at count WIDTH-1 so the counter never wraps.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scr       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_scr <= {bus.in_bcd, {WIDTH{1'b0}}};
            r_cnt <= '0;
            r_err <= w_in_err;
          end
        end
        SHIFT: begin
          r_scr <= w_iter;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_bin   <= r_err ? '0 : w_iter[WIDTH-1:0];
            r_out_err   <= r_err;
          end
        end
        DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin with an expected-result queue.
module tb_bcd2bin;

  localparam int DIGITS = 3;
  localparam int WIDTH  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] bin;
  } exp_t;

  exp_t exp_q[$];

  bcd2bin_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  bcd2bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_conv(input logic [11:0] bcd);
    exp_t e;
    int   v;
    logic [3:0] d0, d1, d2;
    d0 = bcd[3:0];
    d1 = bcd[7:4];
    d2 = bcd[11:8];
    v = int'(d0) + 10 * int'(d1) + 100 * int'(d2);
    e.err = (d0 > 9) || (d1 > 9) || (d2 > 9);
    e.bin = e.err ? '0 : WIDTH'(v);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [11:0] bcd, input bit hold, output int k);
    int n;
    n = 0;
    bus.in_bcd   = bcd;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(ref_conv(bcd));
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int k);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(cyc - k), 32'(WIDTH));
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_bin"}, 32'(bus.out_bin), 32'(e.bin));
      chk({tag, "_err"}, 32'(bus.out_err), 32'(e.err));
    end
  endtask

  task automatic run_one(input string tag, input logic [11:0] bcd);
    int k;
    bus.out_ready = 1'b1;
    accept(bcd, 1'b0, k);
    get_result(tag, k);
    @(negedge clk);
    chk({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int          k;
    int          kprev;
    logic [WIDTH-1:0] held_bin;
    logic        held_err;
    bit          seen;
    logic [11:0] b2b [3];

    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bin",   32'(bus.out_bin),   32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Main conversions and range boundaries
    run_one("c255", 12'h255);
    run_one("c999", 12'h999);
    run_one("c000", 12'h000);
    run_one("c001", 12'h001);
    run_one("c1A3", 12'h1A3);

    // Backpressure: hold DONE while toggling in_valid
    bus.out_ready = 1'b0;
    accept(12'h347, 1'b0, k);
    get_result("bp", k);
    held_bin = bus.out_bin;
    held_err = bus.out_err;
    bus.in_bcd = 12'h111;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      @(negedge clk);
      chk("bp_vld",    32'(bus.out_valid), 32'd1);
      chk("bp_bin",    32'(bus.out_bin),   32'(held_bin));
      chk("bp_err",    32'(bus.out_err),   32'(held_err));
      chk("bp_in_rdy", 32'(bus.in_ready),  32'd0);
    end
    // Release with in_valid high on the same edge: word must not be taken
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_rel_vld",    32'(bus.out_valid), 32'd0);
    chk("bp_rel_in_rdy", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    chk("bp_no_accept",  32'(bus.in_ready),  32'd1);

    // Reset in the middle of converting 0x128
    accept(12'h128, 1'b0, k);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_vld",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_bin",    32'(bus.out_bin),   32'd0);
    chk("mid_rst_in_rdy", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    run_one("c064", 12'h064);

    // Back-to-back with in_valid and out_ready held high
    b2b[0] = 12'h010;
    b2b[1] = 12'h099;
    b2b[2] = 12'h512;
    bus.out_ready = 1'b1;
    kprev = 0;
    for (int i = 0; i < 3; i++) begin
      accept(b2b[i], 1'b1, k);
      if (i > 0) chk("b2b_spacing", 32'(k - kprev), 32'(WIDTH + 2));
      kprev = k;
      get_result("b2b", k);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("b2b_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
